// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder front end.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 8;

  // Bits needed to count 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_add_cell.sv
// Bit-serial Mealy full adder: combinational sum bit, one carry flop with
// synchronous clear and enable.
module serial_add_cell (
  input  logic i_clock,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_a,
  input  logic i_b,
  output logic o_sum
);

  logic r_carry;

  assign o_sum = i_a ^ i_b ^ r_carry;

  always_ff @(posedge i_clock) begin
    if (i_clr) begin
      r_carry <= 1'b0;
    end else if (i_en) begin
      r_carry <= (i_a & i_b) | (r_carry & (i_a ^ i_b));
    end
  end

endmodule

// File: rtl/serial_add_driver.sv
// Word-level front end for the bit-serial adder: latches operands, streams them
// LSB-first, reassembles the serial sum. SERIAL_ADD_DRIVER_INTERNAL_ADDER_EN
// selects the internal serial_add_cell instead of the external S_ser input.
//
// state | meaning
// IDLE  | waiting for Start, operands latched on acceptance
// CLEAR | one cycle clearing the adder carry
// SHIFT | WIDTH+1 cycles streaming bits, extra zero cycle yields the carry
// DONE  | one-cycle Done pulse, Sum/Cout already registered
module serial_add_driver
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a_in,
  input  logic [WIDTH-1:0] i_b_in,
  input  logic             i_s_ser,
  output logic             o_a_ser,
  output logic             o_b_ser,
  output logic             o_adder_en,
  output logic             o_adder_clr,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  state_t         r_state;
  state_t         w_state_next;
  logic [CW-1:0]  r_count;
  logic [WIDTH:0] r_a_sh;
  logic [WIDTH:0] r_b_sh;
  logic [WIDTH:0] r_sum_sh;
  logic [WIDTH:0] w_sum_next;
  logic           w_s;
  logic           w_last;

`ifdef SERIAL_ADD_DRIVER_INTERNAL_ADDER_EN
  logic w_unused_s_ser;
  assign w_unused_s_ser = i_s_ser;

  serial_add_cell u_cell (
    .i_clock (i_clock),
    .i_clr   (o_adder_clr),
    .i_en    (o_adder_en),
    .i_a     (o_a_ser),
    .i_b     (o_b_ser),
    .o_sum   (w_s)
  );
`else
  assign w_s = i_s_ser;
`endif

  assign w_last     = (r_count == LAST_CNT);
  // Sum fills from the MSB side so bit 0 lands in place after WIDTH+1 shifts.
  assign w_sum_next = {w_s, r_sum_sh[WIDTH:1]};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_a_ser      = 1'b0;
    o_b_ser      = 1'b0;
    o_adder_en   = 1'b0;
    o_adder_clr  = i_reset;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_next = CLEAR;
      end
      CLEAR: begin
        o_adder_clr  = 1'b1;
        o_busy       = 1'b1;
        w_state_next = SHIFT;
      end
      SHIFT: begin
        o_a_ser    = r_a_sh[0];
        o_b_ser    = r_b_sh[0];
        o_adder_en = 1'b1;
        o_busy     = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        o_busy       = 1'b1;
        o_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count  <= '0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      o_sum    <= '0;
      o_cout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_a_sh <= {1'b0, i_a_in};
            r_b_sh <= {1'b0, i_b_in};
          end
        end
        CLEAR: begin
          r_count  <= '0;
          r_sum_sh <= '0;
        end
        SHIFT: begin
          r_sum_sh <= w_sum_next;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_count  <= r_count + 1'b1;
          if (w_last) begin
            o_sum  <= w_sum_next[WIDTH-1:0];
            o_cout <= w_sum_next[WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_driver.sv
// Scoreboard bench for serial_add_driver with serial_add_cell as the external adder.
module tb_serial_add_driver;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         s_ser;
  logic         a_ser, b_ser, en, clr, busy, done, cout;
  logic [W-1:0] sum;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accept_cyc = 0;
  logic [W:0] exp_q[$];
  logic [W:0] mon_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_driver #(.WIDTH(W)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_a_in      (a_in),
    .i_b_in      (b_in),
    .i_s_ser     (s_ser),
    .o_a_ser     (a_ser),
    .o_b_ser     (b_ser),
    .o_adder_en  (en),
    .o_adder_clr (clr),
    .o_busy      (busy),
    .o_done      (done),
    .o_sum       (sum),
    .o_cout      (cout)
  );

`ifdef SERIAL_ADD_DRIVER_INTERNAL_ADDER_EN
  assign s_ser = 1'b0;
`else
  serial_add_cell u_model (
    .i_clock (clk),
    .i_clr   (clr),
    .i_en    (en),
    .i_a     (a_ser),
    .i_b     (b_ser),
    .o_sum   (s_ser)
  );
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got {cout,sum}=%0h expected no done", {cout, sum});
      end else begin
        mon_exp = exp_q.pop_front();
        if ({cout, sum} !== mon_exp) begin
          errors++;
          $display("FAIL result: got {cout,sum}=%0h expected %0h", {cout, sum}, mon_exp);
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W:0] e, input bit push);
    @(negedge clk);
    check("clr_idle", clr, 1'b0);
    a_in = a;
    b_in = b;
    start = 1'b1;
    accept_cyc = cyc + 1;
    if (push) exp_q.push_back(e);
  endtask

  task automatic wait_done(output int dc);
    bit found;
    found = 1'b0;
    dc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found = 1'b1;
        dc = cyc;
        break;
      end
    end
    if (!found) begin
      errors++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  task automatic run_wave(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] e);
    logic [W:0] opa, opb;
    int dc;
    opa = {1'b0, a};
    opb = {1'b0, b};
    issue(a, b, e, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("clr_clear", clr, 1'b1);
    check("en_clear", en, 1'b0);
    check("busy_clear", busy, 1'b1);
    for (int i = 0; i <= W; i++) begin
      @(negedge clk);
      check("a_ser", a_ser, opa[i]);
      check("b_ser", b_ser, opb[i]);
      check("en_shift", en, 1'b1);
    end
    wait_done(dc);
    check("latency", dc - accept_cyc, 10);
    @(negedge clk);
    check("sum_held", {cout, sum}, e);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    int dc, first;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 1'b0);
    check("rst_clr", clr, 1'b1);
    check("rst_en", en, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_clr", clr, 1'b0);

    run_wave(8'h55, 8'hAA, 9'h0FF);
    run_wave(8'hFF, 8'h01, 9'h100);

    // Back-to-back with Start held high
    issue(8'h80, 8'h80, 9'h100, 1'b1);
    @(negedge clk);
    a_in = 8'h0F;
    b_in = 8'h01;
    exp_q.push_back(9'h010);
    wait_done(first);
    check("b2b_lat1", first - accept_cyc, 10);
    @(negedge clk);
    check("b2b_idle_busy", busy, 1'b0);
    @(negedge clk);
    check("b2b_restart_busy", busy, 1'b1);
    start = 1'b0;
    wait_done(dc);
    check("b2b_period", dc - first, 12);

    // Start re-pulsed with new operands during SHIFT is ignored
    issue(8'h12, 8'h34, 9'h046, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    a_in = 8'hFF;
    b_in = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    check("busy_during", busy, 1'b1);
    wait_done(dc);
    check("ign_latency", dc - accept_cyc, 10);
    repeat (14) @(negedge clk);
    check("ign_idle_busy", busy, 1'b0);

    // Reset at SHIFT count=4
    issue(8'h21, 8'h13, 9'h034, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_en", en, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sum", sum, 8'h00);
    check("abort_cout", cout, 1'b0);
    check("abort_clr", clr, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_wave(8'h03, 8'h04, 9'h007);

    run_wave(8'h3C, 8'h0F, 9'h04B);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
